// File: rtl/alu_decode_issue_if.sv
// ALU opcode package plus the bundled handshake/bus interface of the decode/issue stage.
// The master modport is the decode/issue stage; the slave modport is its surroundings.
package core_pkg;
    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_SLTS = 2'd2
    } alu_opcode_e;
endpackage

interface alu_decode_issue_if;
    import core_pkg::*;

    logic        instr_valid_ip;
    logic        instr_ready_op;
    logic [31:0] instr_ip;
    logic [31:0] rs1_data_ip;
    logic [31:0] rs2_data_ip;
    logic        alu_enable_op;
    alu_opcode_e alu_operator_op;
    logic [31:0] alu_operand_a_op;
    logic [31:0] alu_operand_b_op;
    logic [31:0] alu_result_ip;
    logic        alu_valid_ip;
    logic        wb_valid_op;
    logic        wb_ready_ip;
    logic [4:0]  wb_rd_op;
    logic [31:0] wb_data_op;
    logic        illegal_op;

    modport master (
        input  instr_valid_ip, instr_ip, rs1_data_ip, rs2_data_ip,
        input  alu_result_ip, alu_valid_ip, wb_ready_ip,
        output instr_ready_op, alu_enable_op, alu_operator_op,
        output alu_operand_a_op, alu_operand_b_op,
        output wb_valid_op, wb_rd_op, wb_data_op, illegal_op
    );

    modport slave (
        output instr_valid_ip, instr_ip, rs1_data_ip, rs2_data_ip,
        output alu_result_ip, alu_valid_ip, wb_ready_ip,
        input  instr_ready_op, alu_enable_op, alu_operator_op,
        input  alu_operand_a_op, alu_operand_b_op,
        input  wb_valid_op, wb_rd_op, wb_data_op, illegal_op
    );
endinterface

// File: rtl/alu_decode_issue.sv
// Decode/issue stage: decodes ADD/SUB/SLT/ADDI/SLTI, issues to the ALU, returns the result to writeback.
// Optional saturating perf counters are enabled by defining ALU_DECODE_PERF_EN.
module alu_decode_issue
    import core_pkg::*;
#(
    parameter int PERF_CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_decode_issue_if.master bus
`ifdef ALU_DECODE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_issued_op,
    output logic [PERF_CNT_W-1:0] perf_illegal_op
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    state_e      state;
    logic        xfer;
    logic        dec_legal;
    alu_opcode_e dec_op;
    logic [31:0] dec_b;
    logic [4:0]  rd_q;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        unused_rs_fields;

    assign opcode           = bus.instr_ip[6:0];
    assign funct3           = bus.instr_ip[14:12];
    assign funct7           = bus.instr_ip[31:25];
    assign unused_rs_fields = ^bus.instr_ip[19:15];

    assign bus.instr_ready_op = (state == IDLE) || ((state == WB) && bus.wb_ready_ip);
    assign xfer               = bus.instr_valid_ip && bus.instr_ready_op;

    // Operand A is always rs1; only operand B depends on register vs immediate form.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_b     = bus.rs2_data_ip;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_ADD;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SUB;
                end else if (funct3 == 3'b010 && funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SLTS;
                end
            end
            7'b0010011: begin
                dec_b = {{20{bus.instr_ip[31]}}, bus.instr_ip[31:20]};
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_ADD;
                end else if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SLTS;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            bus.alu_enable_op    <= 1'b0;
            bus.alu_operator_op  <= ALU_ADD;
            bus.alu_operand_a_op <= '0;
            bus.alu_operand_b_op <= '0;
            bus.wb_valid_op      <= 1'b0;
            bus.wb_rd_op         <= '0;
            bus.wb_data_op       <= '0;
            bus.illegal_op       <= 1'b0;
            rd_q                 <= '0;
        end else begin
            bus.illegal_op <= 1'b0;
            unique case (state)
                IDLE, WB: begin
                    if (state == WB && bus.wb_ready_ip) begin
                        bus.wb_valid_op <= 1'b0;
                        state           <= IDLE;
                    end
                    // A WB slot only accepts once its own result is handed off, so issuing here never clobbers it.
                    if (xfer && dec_legal) begin
                        bus.alu_enable_op    <= 1'b1;
                        bus.alu_operator_op  <= dec_op;
                        bus.alu_operand_a_op <= bus.rs1_data_ip;
                        bus.alu_operand_b_op <= dec_b;
                        rd_q                 <= bus.instr_ip[11:7];
                        state                <= EXEC;
                    end else if (xfer) begin
                        bus.illegal_op <= 1'b1;
                        state          <= IDLE;
                    end
                end
                EXEC: begin
                    bus.alu_enable_op <= 1'b0;
                    if (bus.alu_valid_ip) begin
                        bus.wb_data_op  <= bus.alu_result_ip;
                        bus.wb_rd_op    <= rd_q;
                        bus.wb_valid_op <= 1'b1;
                        state           <= WB;
                    end else begin
                        bus.illegal_op <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_DECODE_PERF_EN
    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued_op  <= '0;
            perf_illegal_op <= '0;
        end else begin
            if (bus.wb_valid_op && bus.wb_ready_ip && perf_issued_op != '1) begin
                perf_issued_op <= perf_issued_op + 1'b1;
            end
            if (bus.illegal_op && perf_illegal_op != '1) begin
                perf_illegal_op <= perf_illegal_op + 1'b1;
            end
        end
    end
`else
    localparam int unused_perf_cnt_w = PERF_CNT_W;
`endif

endmodule

// File: tb/tb_alu_decode_issue.sv
// Self-checking bench for alu_decode_issue: directed spec vectors plus randomized instructions
// checked against an instruction-level reference model; the bench also plays the role of the ALU.
module tb_alu_decode_issue;
    import core_pkg::*;

    localparam int PERF_CNT_W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_decode_issue_if bus ();

`ifdef ALU_DECODE_PERF_EN
    logic [PERF_CNT_W-1:0] perf_issued;
    logic [PERF_CNT_W-1:0] perf_illegal;
`endif

    alu_decode_issue #(.PERF_CNT_W(PERF_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ALU_DECODE_PERF_EN
        ,
        .perf_issued_op  (perf_issued),
        .perf_illegal_op (perf_illegal)
`endif
    );

    // The bench acts as a combinational ALU.
    assign bus.alu_result_ip =
        (bus.alu_operator_op == ALU_SUB)  ? bus.alu_operand_a_op - bus.alu_operand_b_op :
        (bus.alu_operator_op == ALU_SLTS) ? {31'd0, $signed(bus.alu_operand_a_op) < $signed(bus.alu_operand_b_op)} :
                                            bus.alu_operand_a_op + bus.alu_operand_b_op;

    // Instruction-level reference: returns legality, expected operator, operand B and final result.
    function automatic bit model(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                                 output alu_opcode_e op, output logic [31:0] b, output logic [31:0] res);
        int unsigned opc = instr[6:0];
        int unsigned f3  = instr[14:12];
        int unsigned f7  = instr[31:25];
        int          imm = $signed(instr[31:20]);
        bit          ok  = 1'b0;
        op = ALU_ADD;
        b  = rs2;
        if (opc == 'h33) begin
            if (f3 == 0 && f7 == 0)         begin ok = 1; op = ALU_ADD;  end
            else if (f3 == 0 && f7 == 'h20) begin ok = 1; op = ALU_SUB;  end
            else if (f3 == 2 && f7 == 0)    begin ok = 1; op = ALU_SLTS; end
        end else if (opc == 'h13) begin
            b = imm;
            if (f3 == 0)      begin ok = 1; op = ALU_ADD;  end
            else if (f3 == 2) begin ok = 1; op = ALU_SLTS; end
        end
        case (op)
            ALU_SUB:  res = rs1 - b;
            ALU_SLTS: res = (int'(rs1) < int'(b)) ? 32'd1 : 32'd0;
            default:  res = rs1 + b;
        endcase
        return ok;
    endfunction

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.instr_valid_ip = 1'b1;
        bus.instr_ip       = instr;
        bus.rs1_data_ip    = rs1;
        bus.rs2_data_ip    = rs2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.alu_enable_op !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_en: got %0h want 0", bus.alu_enable_op); end
        n_cmp++; if (bus.alu_operator_op !== ALU_ADD) begin n_fail++; $display("[TB] FAIL reset_op: got %0d want %0d", bus.alu_operator_op, ALU_ADD); end
        n_cmp++; if (bus.alu_operand_a_op !== 32'd0 || bus.alu_operand_b_op !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_ab: got %h/%h want 0/0", bus.alu_operand_a_op, bus.alu_operand_b_op); end
        n_cmp++; if (bus.wb_valid_op !== 1'b0 || bus.wb_rd_op !== 5'd0 || bus.wb_data_op !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_wb: got %0h/%0h/%h want 0/0/0", bus.wb_valid_op, bus.wb_rd_op, bus.wb_data_op); end
        n_cmp++; if (bus.illegal_op !== 1'b0 || bus.instr_ready_op !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ill_rdy: got %0h/%0h want 0/1", bus.illegal_op, bus.instr_ready_op); end
`ifdef ALU_DECODE_PERF_EN
        n_cmp++; if (perf_issued !== '0 || perf_illegal !== '0) begin n_fail++; $display("[TB] FAIL reset_perf: got %0d/%0d want 0/0", perf_issued, perf_illegal); end
`endif
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] t_instr [3] = '{32'h002081B3, 32'h40208233, 32'hFFF0A293};
        logic [31:0] t_rs1   [3] = '{32'd5, 32'd5, 32'h80000000};
        logic [31:0] t_rs2   [3] = '{32'd7, 32'd7, 32'd0};
        alu_opcode_e t_op    [3] = '{ALU_ADD, ALU_SUB, ALU_SLTS};
        logic [31:0] t_b     [3] = '{32'd7, 32'd7, 32'hFFFFFFFF};
        logic [4:0]  t_rd    [3] = '{5'd3, 5'd4, 5'd5};
        logic [31:0] t_data  [3] = '{32'd12, 32'hFFFFFFFE, 32'd1};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(t_instr[i], t_rs1[i], t_rs2[i]);
            @(negedge clk);
            bus.instr_valid_ip = 1'b0;
            n_cmp++; if (bus.alu_enable_op !== 1'b1 || bus.wb_valid_op !== 1'b0) begin n_fail++; $display("[TB] FAIL dir%0d_exec_en: got en=%0h wbv=%0h want 1/0", i, bus.alu_enable_op, bus.wb_valid_op); end
            n_cmp++; if (bus.alu_operator_op !== t_op[i]) begin n_fail++; $display("[TB] FAIL dir%0d_op: got %0d want %0d", i, bus.alu_operator_op, t_op[i]); end
            n_cmp++; if (bus.alu_operand_a_op !== t_rs1[i] || bus.alu_operand_b_op !== t_b[i]) begin n_fail++; $display("[TB] FAIL dir%0d_ab: got %h/%h want %h/%h", i, bus.alu_operand_a_op, bus.alu_operand_b_op, t_rs1[i], t_b[i]); end
            @(negedge clk);
            n_cmp++; if (bus.wb_valid_op !== 1'b1 || bus.alu_enable_op !== 1'b0) begin n_fail++; $display("[TB] FAIL dir%0d_wb_valid: got wbv=%0h en=%0h want 1/0", i, bus.wb_valid_op, bus.alu_enable_op); end
            n_cmp++; if (bus.wb_rd_op !== t_rd[i] || bus.wb_data_op !== t_data[i]) begin n_fail++; $display("[TB] FAIL dir%0d_wb_data: got rd=%0d data=%h want %0d/%h", i, bus.wb_rd_op, bus.wb_data_op, t_rd[i], t_data[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        applyStimulus(32'h00000000, 32'd1, 32'd2);
        @(negedge clk);
        bus.instr_valid_ip = 1'b0;
        n_cmp++; if (bus.illegal_op !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_pulse: got %0h want 1", bus.illegal_op); end
        n_cmp++; if (bus.alu_enable_op !== 1'b0 || bus.wb_valid_op !== 1'b0 || bus.instr_ready_op !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_side: got en=%0h wbv=%0h rdy=%0h want 0/0/1", bus.alu_enable_op, bus.wb_valid_op, bus.instr_ready_op); end
        @(negedge clk);
        n_cmp++; if (bus.illegal_op !== 1'b0 || bus.alu_enable_op !== 1'b0 || bus.wb_valid_op !== 1'b0) begin n_fail++; $display("[TB] FAIL ill_after: got ill=%0h en=%0h wbv=%0h want 0/0/0", bus.illegal_op, bus.alu_enable_op, bus.wb_valid_op); end
    endtask

    task automatic test_back_to_back();
        bus.wb_ready_ip = 1'b0;
        applyStimulus(32'h002081B3, 32'd5, 32'd7);
        @(negedge clk);
        bus.instr_valid_ip = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.wb_valid_op !== 1'b1 || bus.wb_rd_op !== 5'd3 || bus.wb_data_op !== 32'd12) begin n_fail++; $display("[TB] FAIL b2b_hold%0d: got v=%0h rd=%0d data=%h want 1/3/0000000c", i, bus.wb_valid_op, bus.wb_rd_op, bus.wb_data_op); end
            n_cmp++; if (bus.instr_ready_op !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_ready_low%0d: got %0h want 0", i, bus.instr_ready_op); end
            @(negedge clk);
        end
        bus.wb_ready_ip = 1'b1;
        applyStimulus(32'h002081B3, 32'd100, 32'd23);
        #1;
        n_cmp++; if (bus.instr_ready_op !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready_high: got %0h want 1", bus.instr_ready_op); end
        @(negedge clk);
        bus.instr_valid_ip = 1'b0;
        n_cmp++; if (bus.alu_enable_op !== 1'b1 || bus.wb_valid_op !== 1'b0 || bus.alu_operand_a_op !== 32'd100 || bus.alu_operand_b_op !== 32'd23) begin n_fail++; $display("[TB] FAIL b2b_exec: got en=%0h wbv=%0h a=%h b=%h want 1/0/64/17", bus.alu_enable_op, bus.wb_valid_op, bus.alu_operand_a_op, bus.alu_operand_b_op); end
        @(negedge clk);
        n_cmp++; if (bus.wb_valid_op !== 1'b1 || bus.wb_data_op !== 32'd123) begin n_fail++; $display("[TB] FAIL b2b_wb: got v=%0h data=%h want 1/0000007b", bus.wb_valid_op, bus.wb_data_op); end
        @(negedge clk);
    endtask

    task automatic test_alu_invalid();
        bus.alu_valid_ip = 1'b0;
        applyStimulus(32'h40208233, 32'd9, 32'd4);
        @(negedge clk);
        bus.instr_valid_ip = 1'b0;
        n_cmp++; if (bus.alu_enable_op !== 1'b1) begin n_fail++; $display("[TB] FAIL aluinv_en: got %0h want 1", bus.alu_enable_op); end
        @(negedge clk);
        bus.alu_valid_ip = 1'b1;
        n_cmp++; if (bus.illegal_op !== 1'b1 || bus.wb_valid_op !== 1'b0 || bus.instr_ready_op !== 1'b1) begin n_fail++; $display("[TB] FAIL aluinv_drop: got ill=%0h wbv=%0h rdy=%0h want 1/0/1", bus.illegal_op, bus.wb_valid_op, bus.instr_ready_op); end
        @(negedge clk);
        n_cmp++; if (bus.illegal_op !== 1'b0 || bus.wb_valid_op !== 1'b0) begin n_fail++; $display("[TB] FAIL aluinv_after: got ill=%0h wbv=%0h want 0/0", bus.illegal_op, bus.wb_valid_op); end
    endtask

    task automatic test_reset_mid();
        applyStimulus(32'h40208233, 32'd33, 32'd11);
        @(negedge clk);
        bus.instr_valid_ip = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.alu_enable_op !== 1'b0 || bus.alu_operator_op !== ALU_ADD) begin n_fail++; $display("[TB] FAIL rstmid_alu: got en=%0h op=%0d want 0/0", bus.alu_enable_op, bus.alu_operator_op); end
        n_cmp++; if (bus.alu_operand_a_op !== 32'd0 || bus.alu_operand_b_op !== 32'd0 || bus.illegal_op !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_ab: got a=%h b=%h ill=%0h want 0/0/0", bus.alu_operand_a_op, bus.alu_operand_b_op, bus.illegal_op); end
        n_cmp++; if (bus.wb_valid_op !== 1'b0 || bus.wb_data_op !== 32'd0 || bus.wb_rd_op !== 5'd0) begin n_fail++; $display("[TB] FAIL rstmid_wb: got v=%0h rd=%0d data=%h want 0/0/0", bus.wb_valid_op, bus.wb_rd_op, bus.wb_data_op); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.wb_valid_op !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_lost: got wbv=%0h want 0", bus.wb_valid_op); end
        applyStimulus(32'h002081B3, 32'd5, 32'd7);
        @(negedge clk);
        bus.instr_valid_ip = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.wb_valid_op !== 1'b1 || bus.wb_rd_op !== 5'd3 || bus.wb_data_op !== 32'd12) begin n_fail++; $display("[TB] FAIL rstmid_recover: got v=%0h rd=%0d data=%h want 1/3/0000000c", bus.wb_valid_op, bus.wb_rd_op, bus.wb_data_op); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] instr, rs1, rs2, exp_b, exp_res;
        alu_opcode_e exp_op;
        bit          legal;
        int          stall, kind, guard;
        for (int n = 0; n < 60; n++) begin
            rs1   = $urandom;
            rs2   = $urandom;
            stall = $urandom_range(0, 2);
            kind  = $urandom_range(0, 6);
            instr = $urandom;
            case (kind)
                0: instr = {7'h00, instr[24:12] & 13'h1F07, instr[11:7], 7'h33} | 32'h0;
                1: instr = {7'h20, instr[24:15], 3'b000, instr[11:7], 7'h33};
                2: instr = {7'h00, instr[24:15], 3'b010, instr[11:7], 7'h33};
                3: instr = {instr[31:15], 3'b000, instr[11:7], 7'h13};
                4: instr = {instr[31:15], 3'b010, instr[11:7], 7'h13};
                5: instr = {instr[31:7], 7'h33};
                default: ;
            endcase
            if (kind == 0) instr[14:12] = 3'b000;
            legal = model(instr, rs1, rs2, exp_op, exp_b, exp_res);
            guard = 0;
            while (bus.instr_ready_op !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) begin
                n_cmp++; n_fail++;
                $display("[TB] FAIL rnd%0d_ready_timeout: got ready=%0h want 1", n, bus.instr_ready_op);
            end
            applyStimulus(instr, rs1, rs2);
            @(negedge clk);
            bus.instr_valid_ip = 1'b0;
            if (!legal) begin
                n_cmp++; if (bus.illegal_op !== 1'b1 || bus.alu_enable_op !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd%0d_illegal: instr=%h got ill=%0h en=%0h want 1/0", n, instr, bus.illegal_op, bus.alu_enable_op); end
            end else begin
                n_cmp++; if (bus.alu_enable_op !== 1'b1 || bus.alu_operator_op !== exp_op) begin n_fail++; $display("[TB] FAIL rnd%0d_issue: instr=%h got en=%0h op=%0d want 1/%0d", n, instr, bus.alu_enable_op, bus.alu_operator_op, exp_op); end
                n_cmp++; if (bus.alu_operand_a_op !== rs1 || bus.alu_operand_b_op !== exp_b) begin n_fail++; $display("[TB] FAIL rnd%0d_ab: instr=%h got %h/%h want %h/%h", n, instr, bus.alu_operand_a_op, bus.alu_operand_b_op, rs1, exp_b); end
                if (stall > 0) bus.wb_ready_ip = 1'b0;
                @(negedge clk);
                for (int s = 0; s <= stall; s++) begin
                    n_cmp++; if (bus.wb_valid_op !== 1'b1 || bus.wb_rd_op !== instr[11:7] || bus.wb_data_op !== exp_res) begin n_fail++; $display("[TB] FAIL rnd%0d_wb%0d: instr=%h got v=%0h rd=%0d data=%h want 1/%0d/%h", n, s, instr, bus.wb_valid_op, bus.wb_rd_op, bus.wb_data_op, instr[11:7], exp_res); end
                    if (s < stall) @(negedge clk);
                end
                bus.wb_ready_ip = 1'b1;
                @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.instr_valid_ip = 1'b0;
        bus.instr_ip       = '0;
        bus.rs1_data_ip    = '0;
        bus.rs2_data_ip    = '0;
        bus.alu_valid_ip   = 1'b1;
        bus.wb_ready_ip    = 1'b1;
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_alu_invalid();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
